ft_sync_fifo_device: RTL and testbench
======================================

FT_SYNC_FIFO_DEVICE -- requirements
Module: ft_sync_fifo_device

Interface
REQ-001 Parameters: DATA_WIDTH, default 8, FIFO bus width; BUFFERS_WIDTH, default 7, buffer address and size width; TURNAROUND, default 1, idle cycles between transfers (range 1..15).
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 in_clk  in  1  single clock; all state changes on its rising edge.
REQ-004 in_rst  in  1  synchronous active-high reset.
REQ-005 in_rd_n  in  1  FPGA read strobe, active low.
REQ-006 in_oe_n  in  1  FPGA output-enable request, active low.
REQ-007 in_wr_n  in  1  FPGA write strobe, active low.
REQ-008 in_data  in  DATA_WIDTH  FPGA-driven bus value.
REQ-009 out_data  out  DATA_WIDTH  device-driven bus value.
REQ-010 out_data_oe  out  1  bus drive enable; tristate buffer lives at top level.
REQ-011 out_rxf_n, out_txe_n  out  1 each  FT2232H-style flags, active low.
REQ-012 usb_tx_start, usb_rx_start  in  1 each  host start pulses.
REQ-013 usb_tx_size, usb_rx_size  in  BUFFERS_WIDTH each  byte counts, sampled on start.
REQ-014 usb_txbuffer_addr  out  BUFFERS_WIDTH, and usb_txbuffer_data  in  DATA_WIDTH  asynchronous-read TX buffer port.
REQ-015 usb_rxbuffer_addr  out  BUFFERS_WIDTH, usb_rxbuffer_data  out  DATA_WIDTH, usb_rxbuffer_wr  out  1  RX buffer write port.
REQ-016 usb_tx_done, usb_rx_done  out  1 each  one-cycle completion pulses; usb_busy  out  1  transfer or turnaround active.

Function
REQ-017 FSM states: IDLE, TX_ACTIVE, RX_ACTIVE, TURN; transitions occur only on rising edges.
REQ-018 A start pulse seen in any state sets a pending flag for its direction and latches its size; a second start while that flag is already set is ignored.
REQ-019 In IDLE with one direction pending: enter that direction next cycle; with both pending: grant the direction not granted last (TX first after reset), giving round-robin order.
REQ-020 Pending size 0: no bus activity; the done pulse asserts the cycle after the grant; return to IDLE.
REQ-021 TX_ACTIVE (USB->FPGA): out_rxf_n=0; usb_txbuffer_addr = bytes already consumed; out_data = usb_txbuffer_data; out_data_oe = !in_oe_n.
REQ-022 A TX byte is consumed on an edge where out_rxf_n=0, in_oe_n=0 and in_rd_n=0, giving a sustained rate of 1 byte/clock.
REQ-023 On the edge consuming the last TX byte: out_rxf_n=1 from the next cycle, usb_tx_done pulses that same next cycle, and the FSM enters TURN.
REQ-024 RX_ACTIVE (FPGA->USB): out_txe_n=0; out_data_oe=0.
REQ-025 An RX byte is accepted on an edge where out_txe_n=0 and in_wr_n=0.
REQ-026 For each accepted RX byte, in the next cycle: usb_rxbuffer_wr=1; usb_rxbuffer_data = the captured in_data; usb_rxbuffer_addr = that byte's index.
REQ-027 On the edge accepting the last RX byte: out_txe_n=1 next cycle; usb_rx_done pulses together with the final usb_rxbuffer_wr; the FSM enters TURN.
REQ-028 Strobes are ignored while the matching flag is high: in_rd_n while out_rxf_n=1, and in_wr_n while out_txe_n=1.
REQ-029 TURN lasts exactly TURNAROUND cycles with both flags high and out_data_oe=0, then the FSM enters IDLE.
REQ-030 Never are out_rxf_n and out_txe_n both 0 (half-duplex bus, full-duplex request queueing).
REQ-031 Counters are BUFFERS_WIDTH wide; a size of 2^BUFFERS_WIDTH-1 completes without wrap; addresses never exceed size-1.

Reset
REQ-032 With in_rst high at an edge:
  - FSM enters IDLE;
  - out_rxf_n=1, out_txe_n=1, out_data_oe=0, out_data=0;
  - usb_rxbuffer_wr=0, done pulses 0, usb_busy=0, both addresses=0;
  - pending flags and latched sizes cleared;
  - round-robin pointer set to TX.
REQ-033 Reset mid-transfer aborts the transfer with no done pulse; a start pulse coincident with reset is dropped.

Structure
REQ-034 A shared package holds the FSM state enum, the direction-grant type and the default TURNAROUND constant.
REQ-035 One sub-module, ft_xfer_counter, is instantiated once per direction and provides a loadable size register, an index counter and a last-byte flag.

Verification
REQ-036 Reset, then usb_tx_size=4 start, in_oe_n/in_rd_n held low -> four consecutive bytes buf[0..3], out_rxf_n high after the 4th, usb_tx_done one pulse.
REQ-037 usb_rx_size=3, in_wr_n low 3 cycles with data 0xA1,0xA2,0xA3 -> writes at addr 0,1,2 with those values, usb_rx_done coincident with the 3rd write.
REQ-038 tx_start and rx_start in the same cycle after reset -> TX runs first, TURNAROUND idle cycles, then RX; a repeat of both starts -> RX runs first.
REQ-039 usb_rx_size=0 start -> usb_rx_done the cycle after grant, out_txe_n never low, no usb_rxbuffer_wr.
REQ-040 in_rst asserted after 2 of 5 TX bytes -> flags high next cycle, no usb_tx_done; a new size=1 start then completes normally.
REQ-041 in_wr_n low during TX_ACTIVE and in_rd_n toggling with in_oe_n high -> no RX write, no TX byte consumed, out_data_oe=0.

Source files
------------

// File: rtl/ft_sync_fifo_device_pkg.sv
// Shared types and constants for the FT2232H-style synchronous FIFO device model.
//   fifo_state_t       : sequencer states (idle, USB->FPGA, FPGA->USB, bus turnaround)
//   grant_t            : direction selected by the round-robin arbiter
//   TURNAROUND_DEFAULT : default number of idle bus cycles between transfers
package ft_sync_fifo_device_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_TX_ACTIVE = 2'd1,
        ST_RX_ACTIVE = 2'd2,
        ST_TURN      = 2'd3
    } fifo_state_t;

    typedef enum logic {
        GRANT_TX = 1'b0,
        GRANT_RX = 1'b1
    } grant_t;

    localparam int TURNAROUND_DEFAULT = 1;

endpackage

// File: rtl/ft_sync_fifo_device_xfer_counter.sv
// Per-direction transfer bookkeeping: a loadable byte-count register, the
// index of the next byte and flags for "next byte is the last" / "empty transfer".
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture load_size into the size register
//   advance    : one byte moved; index steps, or returns to 0 after the last byte
//   idx        : index of the byte currently presented / expected
//   last       : idx addresses the final byte of the transfer
//   zero       : latched size is zero
module ft_xfer_counter
    import ft_sync_fifo_device_pkg::*;
#(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_size,
    input  logic             advance,
    output logic [WIDTH-1:0] idx,
    output logic             last,
    output logic             zero
);

    logic [WIDTH-1:0] size;

    always_ff @(posedge clk) begin
        if (rst) begin
            size <= '0;
            idx  <= '0;
        end else begin
            if (load) begin
                size <= load_size;
            end
            // Returning to 0 after the final byte keeps the address inside
            // 0..size-1 and avoids wrapping on a full-width size.
            if (advance) begin
                idx <= last ? '0 : idx + WIDTH'(1);
            end
        end
    end

    assign last = (idx == size - WIDTH'(1));
    assign zero = (size == '0);

endmodule

// File: rtl/ft_sync_fifo_device.sv
// Behavioural model of an FT2232H-style synchronous 245 FIFO seen from the FPGA.
// The host side queues TX (USB->FPGA) and RX (FPGA->USB) transfers with start
// pulses; the device serves them one at a time over the half-duplex bus,
// separated by TURNAROUND idle cycles, with round-robin arbitration.
//   in_clk, in_rst                  : clock, synchronous active-high reset
//   in_rd_n, in_oe_n, in_wr_n       : FPGA strobes, active low
//   in_data / out_data, out_data_oe : bus in, bus out and its drive enable
//   out_rxf_n, out_txe_n            : data-available / space-available flags
//   usb_tx_*, usb_rx_*              : host start/size, buffer ports, done pulses
//   usb_busy                        : transfer or turnaround in progress
//
// state        | meaning
// ST_IDLE      | no transfer; arbitrate pending requests
// ST_TX_ACTIVE | rxf_n low, FPGA reads bytes from the TX buffer
// ST_RX_ACTIVE | txe_n low, FPGA writes bytes into the RX buffer
// ST_TURN      | both flags high for TURNAROUND cycles
module ft_sync_fifo_device
    import ft_sync_fifo_device_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int BUFFERS_WIDTH = 7,
    parameter int TURNAROUND    = TURNAROUND_DEFAULT
) (
    input  logic                     in_clk,
    input  logic                     in_rst,
    input  logic                     in_rd_n,
    input  logic                     in_oe_n,
    input  logic                     in_wr_n,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_data_oe,
    output logic                     out_rxf_n,
    output logic                     out_txe_n,
    input  logic                     usb_tx_start,
    input  logic                     usb_rx_start,
    input  logic [BUFFERS_WIDTH-1:0] usb_tx_size,
    input  logic [BUFFERS_WIDTH-1:0] usb_rx_size,
    output logic [BUFFERS_WIDTH-1:0] usb_txbuffer_addr,
    input  logic [DATA_WIDTH-1:0]    usb_txbuffer_data,
    output logic [BUFFERS_WIDTH-1:0] usb_rxbuffer_addr,
    output logic [DATA_WIDTH-1:0]    usb_rxbuffer_data,
    output logic                     usb_rxbuffer_wr,
    output logic                     usb_tx_done,
    output logic                     usb_rx_done,
    output logic                     usb_busy
);

    fifo_state_t state, state_next;
    grant_t      rr_next;

    logic pend_tx, pend_rx;
    logic tx_load, rx_load;
    logic tx_take, rx_take;
    logic tx_fin, rx_fin;
    logic grant_tx, grant_rx;
    logic contested;

    logic [BUFFERS_WIDTH-1:0] tx_idx, rx_idx;
    logic tx_last, rx_last, tx_zero, rx_zero;

    logic [3:0]                turn_cnt;
    logic                      tx_done_q, rx_done_q, rx_wr_q;
    logic [DATA_WIDTH-1:0]     rx_data_q;
    logic [BUFFERS_WIDTH-1:0]  rx_addr_q;

    // A start is only accepted while its direction is free; the flag stays set
    // until the transfer completes, so the latched size cannot change mid-transfer.
    assign tx_load = usb_tx_start && !pend_tx;
    assign rx_load = usb_rx_start && !pend_rx;

    assign contested = pend_tx && pend_rx;
    assign grant_tx  = (state == ST_IDLE) && pend_tx && (!pend_rx || rr_next == GRANT_TX);
    assign grant_rx  = (state == ST_IDLE) && pend_rx && !grant_tx;

    assign tx_take = (state == ST_TX_ACTIVE) && !in_oe_n && !in_rd_n;
    assign rx_take = (state == ST_RX_ACTIVE) && !in_wr_n;

    // Empty transfers finish straight from the grant without touching the bus.
    assign tx_fin = (tx_take && tx_last) || (grant_tx && tx_zero);
    assign rx_fin = (rx_take && rx_last) || (grant_rx && rx_zero);

    ft_xfer_counter #(.WIDTH(BUFFERS_WIDTH)) u_tx_cnt (
        .clk       (in_clk),
        .rst       (in_rst),
        .load      (tx_load),
        .load_size (usb_tx_size),
        .advance   (tx_take),
        .idx       (tx_idx),
        .last      (tx_last),
        .zero      (tx_zero)
    );

    ft_xfer_counter #(.WIDTH(BUFFERS_WIDTH)) u_rx_cnt (
        .clk       (in_clk),
        .rst       (in_rst),
        .load      (rx_load),
        .load_size (usb_rx_size),
        .advance   (rx_take),
        .idx       (rx_idx),
        .last      (rx_last),
        .zero      (rx_zero)
    );

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        out_rxf_n   = 1'b1;
        out_txe_n   = 1'b1;
        out_data_oe = 1'b0;
        out_data    = '0;
        usb_busy    = 1'b1;
        case (state)
            ST_IDLE: begin
                usb_busy = 1'b0;
                if (grant_tx && !tx_zero) begin
                    state_next = ST_TX_ACTIVE;
                end else if (grant_rx && !rx_zero) begin
                    state_next = ST_RX_ACTIVE;
                end
            end
            ST_TX_ACTIVE: begin
                out_rxf_n   = 1'b0;
                out_data    = usb_txbuffer_data;
                out_data_oe = !in_oe_n;
                if (tx_take && tx_last) begin
                    state_next = ST_TURN;
                end
            end
            ST_RX_ACTIVE: begin
                out_txe_n = 1'b0;
                if (rx_take && rx_last) begin
                    state_next = ST_TURN;
                end
            end
            ST_TURN: begin
                if (turn_cnt == 4'd0) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            pend_tx   <= 1'b0;
            pend_rx   <= 1'b0;
            rr_next   <= GRANT_TX;
            turn_cnt  <= 4'd0;
            tx_done_q <= 1'b0;
            rx_done_q <= 1'b0;
            rx_wr_q   <= 1'b0;
            rx_data_q <= '0;
            rx_addr_q <= '0;
        end else begin
            pend_tx   <= tx_fin ? 1'b0 : (pend_tx || usb_tx_start);
            pend_rx   <= rx_fin ? 1'b0 : (pend_rx || usb_rx_start);
            tx_done_q <= tx_fin;
            rx_done_q <= rx_fin;
            rx_wr_q   <= rx_take;
            if (rx_take) begin
                rx_data_q <= in_data;
                rx_addr_q <= rx_idx;
            end
            // The pointer only moves when both directions competed, so an
            // uncontested grant does not steal the other side's next turn.
            if (state == ST_IDLE && contested) begin
                rr_next <= grant_tx ? GRANT_RX : GRANT_TX;
            end
            // Down-counter loaded on TURN entry; state leaves TURN at terminal count.
            if (state != ST_TURN && state_next == ST_TURN) begin
                turn_cnt <= 4'(TURNAROUND - 1);
            end else if (state == ST_TURN && turn_cnt != 4'd0) begin
                turn_cnt <= turn_cnt - 4'd1;
            end
        end
    end

    assign usb_txbuffer_addr = tx_idx;
    assign usb_rxbuffer_addr = rx_addr_q;
    assign usb_rxbuffer_data = rx_data_q;
    assign usb_rxbuffer_wr   = rx_wr_q;
    assign usb_tx_done       = tx_done_q;
    assign usb_rx_done       = rx_done_q;

endmodule

// File: tb/tb_ft_sync_fifo_device.sv
// Scoreboard bench for ft_sync_fifo_device: stimulus tasks push expected bus
// bytes, RX buffer writes and completion order into queues; a negedge monitor
// pops and compares whenever the DUT presents data, a write or a done pulse.
module tb_ft_sync_fifo_device;

    localparam int DW = 8;
    localparam int BW = 7;
    localparam int TA = 3;

    logic          clk = 1'b0;
    logic          in_rst = 1'b1;
    logic          in_rd_n = 1'b1, in_oe_n = 1'b1, in_wr_n = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic [DW-1:0] out_data;
    logic          out_data_oe, out_rxf_n, out_txe_n;
    logic          usb_tx_start = 1'b0, usb_rx_start = 1'b0;
    logic [BW-1:0] usb_tx_size = '0, usb_rx_size = '0;
    logic [BW-1:0] usb_txbuffer_addr, usb_rxbuffer_addr;
    logic [DW-1:0] usb_txbuffer_data, usb_rxbuffer_data;
    logic          usb_rxbuffer_wr, usb_tx_done, usb_rx_done, usb_busy;

    logic [DW-1:0] tx_mem [0:(1<<BW)-1];
    assign usb_txbuffer_data = tx_mem[usb_txbuffer_addr];

    always #5 clk = ~clk;

    ft_sync_fifo_device #(.DATA_WIDTH(DW), .BUFFERS_WIDTH(BW), .TURNAROUND(TA)) dut (
        .in_clk            (clk),
        .in_rst            (in_rst),
        .in_rd_n           (in_rd_n),
        .in_oe_n           (in_oe_n),
        .in_wr_n           (in_wr_n),
        .in_data           (in_data),
        .out_data          (out_data),
        .out_data_oe       (out_data_oe),
        .out_rxf_n         (out_rxf_n),
        .out_txe_n         (out_txe_n),
        .usb_tx_start      (usb_tx_start),
        .usb_rx_start      (usb_rx_start),
        .usb_tx_size       (usb_tx_size),
        .usb_rx_size       (usb_rx_size),
        .usb_txbuffer_addr (usb_txbuffer_addr),
        .usb_txbuffer_data (usb_txbuffer_data),
        .usb_rxbuffer_addr (usb_rxbuffer_addr),
        .usb_rxbuffer_data (usb_rxbuffer_data),
        .usb_rxbuffer_wr   (usb_rxbuffer_wr),
        .usb_tx_done       (usb_tx_done),
        .usb_rx_done       (usb_rx_done),
        .usb_busy          (usb_busy)
    );

    typedef struct packed {
        logic [BW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t exp_tx[$];
    beat_t exp_rx[$];
    int    exp_done[$];   // 0 = TX done expected, 1 = RX done expected

    int checks = 0, errors = 0;
    int cyc = 0;
    int done_cnt = 0, rxf_low_cycles = 0, txe_low_cycles = 0;
    int last_tx_done_cyc = 0, last_rx_done_cyc = 0, tx_act_cyc = 0, rx_act_cyc = 0;
    int issue_cyc = 0, rx_total = 0, rx_sent = 0;
    int rr_ptr = 0;       // reference arbiter: direction favoured on the next tie
    logic prev_rxf = 1'b1, prev_txe = 1'b1;
    beat_t mon_e;
    int    mon_d;

    function automatic void chk_eq(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void fail_now(string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: samples on the falling edge, when all DUT outputs are stable.
    always @(negedge clk) begin
        if (!in_rst) begin
            if (!out_rxf_n || !out_txe_n) begin
                chk_eq("flags_exclusive", int'(out_rxf_n | out_txe_n), 1);
                chk_eq("busy_while_active", int'(usb_busy), 1);
            end
            if (!out_rxf_n) rxf_low_cycles++;
            if (!out_txe_n) txe_low_cycles++;
            if (!out_rxf_n && prev_rxf) tx_act_cyc = cyc;
            if (!out_txe_n && prev_txe) rx_act_cyc = cyc;
            if (!out_rxf_n) begin
                chk_eq("tx_data_oe", int'(out_data_oe), int'(!in_oe_n));
                if (!in_oe_n && !in_rd_n) begin
                    if (exp_tx.size() == 0) begin
                        fail_now("tx_unexpected_byte");
                    end else begin
                        mon_e = exp_tx.pop_front();
                        chk_eq("tx_addr", int'(usb_txbuffer_addr), int'(mon_e.addr));
                        chk_eq("tx_data", int'(out_data), int'(mon_e.data));
                    end
                end
            end else begin
                chk_eq("data_oe_off", int'(out_data_oe), 0);
            end
            if (usb_rxbuffer_wr) begin
                if (exp_rx.size() == 0) begin
                    fail_now("rx_unexpected_write");
                end else begin
                    mon_e = exp_rx.pop_front();
                    chk_eq("rx_addr", int'(usb_rxbuffer_addr), int'(mon_e.addr));
                    chk_eq("rx_data", int'(usb_rxbuffer_data), int'(mon_e.data));
                    chk_eq("rx_done_with_last", int'(usb_rx_done), int'(mon_e.last));
                end
            end
            if (usb_tx_done) begin
                done_cnt++;
                last_tx_done_cyc = cyc;
                if (exp_done.size() == 0) begin
                    fail_now("tx_unexpected_done");
                end else begin
                    mon_d = exp_done.pop_front();
                    chk_eq("done_order_tx", 0, mon_d);
                end
                chk_eq("tx_bytes_left_at_done", exp_tx.size(), 0);
                chk_eq("rxf_high_at_done", int'(out_rxf_n), 1);
            end
            if (usb_rx_done) begin
                done_cnt++;
                last_rx_done_cyc = cyc;
                if (exp_done.size() == 0) begin
                    fail_now("rx_unexpected_done");
                end else begin
                    mon_d = exp_done.pop_front();
                    chk_eq("done_order_rx", 1, mon_d);
                end
                chk_eq("rx_writes_left_at_done", exp_rx.size(), 0);
                chk_eq("txe_high_at_done", int'(out_txe_n), 1);
            end
        end
        prev_rxf = out_rxf_n;
        prev_txe = out_txe_n;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        in_rd_n = 1'b1;
        in_oe_n = 1'b1;
        in_wr_n = 1'b1;
    endtask

    task automatic flush_model();
        exp_tx.delete();
        exp_rx.delete();
        exp_done.delete();
        rr_ptr = 0;
    endtask

    task automatic do_reset();
        in_rst = 1'b1;
        usb_tx_start = 1'b0;
        usb_rx_start = 1'b0;
        idle_bus();
        tick();
        tick();
        flush_model();
        in_rst = 1'b0;
    endtask

    // Queue one or both transfers; the reference arbiter orders ties.
    task automatic issue(bit do_tx, int tx_n, bit do_rx, int rx_n);
        beat_t b;
        if (do_tx) begin
            for (int i = 0; i < tx_n; i++) begin
                tx_mem[i] = DW'($urandom);
                b.addr = BW'(i);
                b.data = tx_mem[i];
                b.last = (i == tx_n - 1);
                exp_tx.push_back(b);
            end
            usb_tx_start = 1'b1;
            usb_tx_size  = BW'(tx_n);
        end
        if (do_rx) begin
            rx_total = rx_n;
            rx_sent  = 0;
            usb_rx_start = 1'b1;
            usb_rx_size  = BW'(rx_n);
        end
        if (do_tx && do_rx) begin
            exp_done.push_back(rr_ptr);
            exp_done.push_back(1 - rr_ptr);
            rr_ptr = 1 - rr_ptr;
        end else if (do_tx) begin
            exp_done.push_back(0);
        end else if (do_rx) begin
            exp_done.push_back(1);
        end
        issue_cyc = cyc;
        tick();
        usb_tx_start = 1'b0;
        usb_rx_start = 1'b0;
    endtask

    // FPGA side of the bus. mode 0: full rate; 1: random stalls and stray
    // strobes; 2: first three TX cycles with oe_n high, rd_n toggling and
    // wr_n low; 3: full rate with RX data 0xA1, 0xA2, ...
    task automatic serve(int n_dones, int mode, int budget);
        int target;
        int k;
        int spur;
        bit wr;
        target = done_cnt + n_dones;
        k = 0;
        spur = 0;
        while (done_cnt < target && k < budget) begin
            in_data = (mode == 3) ? DW'(8'hA1 + rx_sent) : DW'($urandom);
            if (!out_rxf_n) begin
                if (mode == 2 && spur < 3) begin
                    in_oe_n = 1'b1;
                    in_rd_n = spur[0];
                    in_wr_n = 1'b0;
                    spur++;
                end else if (mode == 1) begin
                    in_oe_n = ($urandom_range(0, 4) == 0);
                    in_rd_n = ($urandom_range(0, 2) == 0);
                    in_wr_n = 1'($urandom_range(0, 1));
                end else begin
                    in_oe_n = 1'b0;
                    in_rd_n = 1'b0;
                    in_wr_n = 1'b1;
                end
            end else if (!out_txe_n) begin
                wr = (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
                in_wr_n = !wr;
                in_rd_n = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
                in_oe_n = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
                if (wr) begin
                    exp_rx.push_back('{addr: BW'(rx_sent), data: in_data,
                                       last: (rx_sent == rx_total - 1)});
                    rx_sent++;
                end
            end else if (mode == 1) begin
                in_oe_n = 1'($urandom_range(0, 1));
                in_rd_n = 1'($urandom_range(0, 1));
                in_wr_n = 1'($urandom_range(0, 1));
            end else begin
                idle_bus();
            end
            tick();
            k++;
        end
        idle_bus();
        if (done_cnt < target) fail_now("serve_timeout");
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (usb_busy && k < 100) begin
            tick();
            k++;
        end
        if (usb_busy) fail_now("idle_timeout");
        tick();
    endtask

    initial begin
        int r0, t0, d0, n1, n2, consumed, sel, ts, rs;
        for (int i = 0; i < (1 << BW); i++) tx_mem[i] = '0;

        // Reset values
        do_reset();
        chk_eq("rst_rxf_n", int'(out_rxf_n), 1);
        chk_eq("rst_txe_n", int'(out_txe_n), 1);
        chk_eq("rst_data_oe", int'(out_data_oe), 0);
        chk_eq("rst_out_data", int'(out_data), 0);
        chk_eq("rst_rx_wr", int'(usb_rxbuffer_wr), 0);
        chk_eq("rst_tx_done", int'(usb_tx_done), 0);
        chk_eq("rst_rx_done", int'(usb_rx_done), 0);
        chk_eq("rst_busy", int'(usb_busy), 0);
        chk_eq("rst_tx_addr", int'(usb_txbuffer_addr), 0);
        chk_eq("rst_rx_addr", int'(usb_rxbuffer_addr), 0);

        // Four-byte TX at full rate
        r0 = rxf_low_cycles;
        d0 = done_cnt;
        issue(1, 4, 0, 0);
        serve(1, 0, 50);
        wait_idle();
        chk_eq("tx4_rxf_low_cycles", rxf_low_cycles - r0, 4);
        chk_eq("tx4_done_pulses", done_cnt - d0, 1);

        // Three-byte RX with data A1, A2, A3
        t0 = txe_low_cycles;
        issue(0, 0, 1, 3);
        serve(1, 3, 50);
        wait_idle();
        chk_eq("rx3_txe_low_cycles", txe_low_cycles - t0, 3);

        // Simultaneous starts: TX first, then RX after the turnaround; repeat flips order
        n1 = $urandom_range(1, 6);
        n2 = $urandom_range(1, 6);
        issue(1, n1, 1, n2);
        serve(2, 0, 200);
        chk_eq("tie1_turnaround_gap", rx_act_cyc - last_tx_done_cyc, TA + 1);
        wait_idle();
        issue(1, n2, 1, n1);
        serve(2, 0, 200);
        chk_eq("tie2_turnaround_gap", tx_act_cyc - last_rx_done_cyc, TA + 1);
        wait_idle();

        // Zero-size RX: done two cycles after the start, bus untouched
        t0 = txe_low_cycles;
        issue(0, 0, 1, 0);
        serve(1, 0, 20);
        chk_eq("rx0_done_latency", last_rx_done_cyc - issue_cyc, 2);
        chk_eq("rx0_txe_low_cycles", txe_low_cycles - t0, 0);
        wait_idle();

        // Stray strobes during TX must not move data
        issue(1, 4, 0, 0);
        serve(1, 2, 60);
        wait_idle();

        // Reset after two of five TX bytes aborts without a done pulse
        issue(1, 5, 0, 0);
        consumed = 0;
        for (int k = 0; k < 40 && consumed < 2; k++) begin
            if (!out_rxf_n) begin
                in_oe_n = 1'b0;
                in_rd_n = 1'b0;
                consumed++;
            end
            tick();
        end
        idle_bus();
        in_rst = 1'b1;
        tick();
        flush_model();
        in_rst = 1'b0;
        chk_eq("abort_rxf_n", int'(out_rxf_n), 1);
        chk_eq("abort_txe_n", int'(out_txe_n), 1);
        chk_eq("abort_busy", int'(usb_busy), 0);
        d0 = done_cnt;
        repeat (6) tick();
        chk_eq("abort_no_done", done_cnt - d0, 0);
        issue(1, 1, 0, 0);
        serve(1, 0, 30);
        wait_idle();

        // Randomized traffic, ending with full-size transfers in both directions
        for (int it = 0; it < 26; it++) begin
            sel = $urandom_range(0, 2);
            ts = $urandom_range(0, 12);
            rs = $urandom_range(0, 12);
            if (it == 25) begin
                sel = 2;
                ts = (1 << BW) - 1;
                rs = (1 << BW) - 1;
            end
            issue(sel != 1, ts, sel != 0, rs);
            serve((sel == 2) ? 2 : 1, 1, 3000);
            wait_idle();
        end

        chk_eq("end_tx_queue_empty", exp_tx.size(), 0);
        chk_eq("end_rx_queue_empty", exp_rx.size(), 0);
        chk_eq("end_done_queue_empty", exp_done.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
